// File: rtl/game_pkg.sv
// Shared definitions for the game speed controller: FSM states and the
// level-clamp / tick-period helpers.
package game_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ARM  = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  function automatic logic [31:0] clamp_level(input logic [31:0] lvl, input int unsigned levels);
    return (lvl >= levels) ? 32'(levels - 1) : lvl;
  endfunction

  // Faster levels halve the period; never drop below one clock.
  function automatic logic [31:0] period_of(input int unsigned base, input logic [31:0] s);
    logic [31:0] p;
    p = 32'(base) >> s;
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/game_speed_ctrl_if.sv
// Switch-side bundle of the speed controller: raw selection in, speed/status out.
interface game_speed_ctrl_if #(
  parameter int unsigned LW = 2
);
  logic [LW-1:0] level;
  logic          ready;
  logic [LW-1:0] gameSpeed;
  logic          control;
  logic          tick;
  logic          at_max;

  modport master (output level, ready, input gameSpeed, control, tick, at_max);
  modport slave  (input level, ready, output gameSpeed, control, tick, at_max);
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: strobes tick on the last count of each period while enabled.
module tick_prescaler #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == (period - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!en || clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_speed_ctrl.sv
// Difficulty selector: arms on ready, tracks the switches, locks on ready release,
// then drives the game-step tick and optionally climbs levels on its own.
module game_speed_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LEVELS      = 4,
  parameter int unsigned LW          = $clog2(LEVELS),
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned BASE_PERIOD = 50_000_000,
  parameter int unsigned AUTO_ADV    = 0,
  parameter int unsigned ADV_TICKS   = 32
) (
  input logic              clk,
  input logic              rst,
  game_speed_ctrl_if.slave bus
);

  localparam int unsigned AW = (ADV_TICKS > 1) ? $clog2(ADV_TICKS) : 1;

  state_e        state_q;
  logic [LW-1:0] speed_q;
  logic          ctrl_q;
  logic [AW-1:0] adv_cnt_q;

  logic             tick;
  logic             adv_last;
  logic             adv_fire;
  logic [CNT_W-1:0] period;

  assign period   = CNT_W'(period_of(BASE_PERIOD, 32'(speed_q)));
  assign adv_last = (adv_cnt_q == AW'(ADV_TICKS - 1));
  // Advance restarts the prescaler so the new period counts from zero.
  assign adv_fire = (AUTO_ADV != 0) && tick && adv_last && (speed_q != LW'(LEVELS - 1));

  tick_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == S_LOCK),
    .clr    (adv_fire),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_WAIT;
      speed_q   <= '0;
      ctrl_q    <= 1'b0;
      adv_cnt_q <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (bus.ready) state_q <= S_ARM;
        end
        S_ARM: begin
          speed_q <= LW'(clamp_level(32'(bus.level), LEVELS));
          if (!bus.ready) begin
            state_q <= S_LOCK;
            ctrl_q  <= 1'b1;
          end
        end
        S_LOCK: begin
          if ((AUTO_ADV != 0) && tick) begin
            adv_cnt_q <= adv_last ? '0 : adv_cnt_q + AW'(1);
            if (adv_fire) speed_q <= speed_q + LW'(1);
          end
        end
        default: begin
          state_q   <= S_WAIT;
          speed_q   <= '0;
          ctrl_q    <= 1'b0;
          adv_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.gameSpeed = speed_q;
  assign bus.control   = ctrl_q;
  assign bus.tick      = tick;
  assign bus.at_max    = (speed_q == LW'(LEVELS - 1));

endmodule

// File: tb/tb_game_speed_ctrl.sv
// Directed bench for game_speed_ctrl: three configurations sharing one clock and reset.
module tb_game_speed_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  game_speed_ctrl_if #(.LW(2)) bus_a ();
  game_speed_ctrl_if #(.LW(2)) bus_b ();
  game_speed_ctrl_if #(.LW(2)) bus_c ();

  game_speed_ctrl #(
    .LEVELS(4), .LW(2), .CNT_W(8), .BASE_PERIOD(16), .AUTO_ADV(0), .ADV_TICKS(32)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  game_speed_ctrl #(
    .LEVELS(3), .LW(2), .CNT_W(8), .BASE_PERIOD(16), .AUTO_ADV(0), .ADV_TICKS(32)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  game_speed_ctrl #(
    .LEVELS(4), .LW(2), .CNT_W(8), .BASE_PERIOD(16), .AUTO_ADV(1), .ADV_TICKS(2)
  ) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int exp_spd;
  logic exp_tick;

  initial begin
    bus_a.level = '0; bus_a.ready = 1'b0;
    bus_b.level = '0; bus_b.ready = 1'b0;
    bus_c.level = '0; bus_c.ready = 1'b0;

    // Reset state
    #3 rst = 1'b0;
    #1;
    chk("rst_speed", 32'(bus_a.gameSpeed), 0);
    chk("rst_control", 32'(bus_a.control), 0);
    chk("rst_tick", 32'(bus_a.tick), 0);
    chk("rst_at_max", 32'(bus_a.at_max), 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // A: level tracking 1 -> 3 -> 0 while armed, lock at 0 (period 16)
    bus_a.ready = 1'b1; bus_a.level = 2'd1;
    step(1);
    chk("arm_speed0", 32'(bus_a.gameSpeed), 0);
    step(1);
    chk("track_1", 32'(bus_a.gameSpeed), 1);
    bus_a.level = 2'd3;
    step(1);
    chk("track_3", 32'(bus_a.gameSpeed), 3);
    chk("track_ctrl", 32'(bus_a.control), 0);
    bus_a.level = 2'd0;
    step(1);
    chk("track_0", 32'(bus_a.gameSpeed), 0);
    bus_a.ready = 1'b0;
    step(1);
    chk("lock_speed", 32'(bus_a.gameSpeed), 0);
    chk("lock_ctrl", 32'(bus_a.control), 1);
    chk("lock_tick", 32'(bus_a.tick), 0);
    // Cadence of 16; from cycle 17 the switches toggle and must be ignored
    for (int i = 1; i <= 40; i++) begin
      if (i >= 17) begin
        bus_a.ready = i[0];
        bus_a.level = 2'(i);
      end
      step(1);
      chk("a_tick", 32'(bus_a.tick), 32'((i % 16) == 15));
      chk("a_speed", 32'(bus_a.gameSpeed), 0);
      chk("a_ctrl", 32'(bus_a.control), 1);
    end

    // B: LEVELS=3, level 3 clamps to 2, period 4
    bus_b.ready = 1'b1; bus_b.level = 2'd3;
    step(2);
    bus_b.ready = 1'b0;
    step(1);
    chk("b_clamp", 32'(bus_b.gameSpeed), 2);
    chk("b_at_max", 32'(bus_b.at_max), 1);
    chk("b_ctrl", 32'(bus_b.control), 1);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("b_tick", 32'(bus_b.tick), 32'((i % 4) == 3));
    end

    // C: auto-advance 0->1 @32, 1->2 @48, 2->3 @56, then ticks every 2
    bus_c.ready = 1'b1; bus_c.level = 2'd0;
    step(2);
    bus_c.ready = 1'b0;
    step(1);
    chk("c_lock_speed", 32'(bus_c.gameSpeed), 0);
    chk("c_lock_ctrl", 32'(bus_c.control), 1);
    for (int k = 1; k <= 61; k++) begin
      step(1);
      if (k < 32) begin
        exp_spd = 0; exp_tick = (k % 16) == 15;
      end else if (k < 48) begin
        exp_spd = 1; exp_tick = ((k - 32) % 8) == 7;
      end else if (k < 56) begin
        exp_spd = 2; exp_tick = ((k - 48) % 4) == 3;
      end else begin
        exp_spd = 3; exp_tick = ((k - 56) % 2) == 1;
      end
      chk("c_speed", 32'(bus_c.gameSpeed), 32'(exp_spd));
      chk("c_tick", 32'(bus_c.tick), 32'(exp_tick));
      chk("c_at_max", 32'(bus_c.at_max), 32'(exp_spd == 3));
    end

    // Async reset between edges while C's tick is high
    chk("pre_rst_tick", 32'(bus_c.tick), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_c_speed", 32'(bus_c.gameSpeed), 0);
    chk("arst_c_ctrl", 32'(bus_c.control), 0);
    chk("arst_c_tick", 32'(bus_c.tick), 0);
    chk("arst_c_at_max", 32'(bus_c.at_max), 0);
    chk("arst_a_ctrl", 32'(bus_a.control), 0);
    chk("arst_b_speed", 32'(bus_b.gameSpeed), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    // Back in S_WAIT: level is ignored while ready is low
    bus_c.level = 2'd2; bus_c.ready = 1'b0;
    step(3);
    chk("post_rst_speed", 32'(bus_c.gameSpeed), 0);
    chk("post_rst_ctrl", 32'(bus_c.control), 0);
    chk("post_rst_tick", 32'(bus_c.tick), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_speed_ctrl.md
# game_speed_ctrl

Parametrised successor of the two-switch speed selector. Latches a user-selected difficulty level from the switch bank through a ready-switch arm/release handshake, then holds the selection and drives a `control` flag. It also generates the game-step `tick` strobe whose period shrinks with level, and can optionally auto-advance the level during play. It sits between the board switches and the random-number/timer logic, replacing the fixed three-level selector.

## Interface
- `LEVELS`, 4: number of speed levels, 2..16.
- `LW`, $clog2(LEVELS): width of the level and speed codes.
- `CNT_W`, 26: prescaler counter width; must hold `BASE_PERIOD`.
- `BASE_PERIOD`, 50_000_000: tick period in clocks at level 0.
- `AUTO_ADV`, 0: 1 enables automatic level advance during play.
- `ADV_TICKS`, 32: ticks spent at a level before auto-advance, ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous and active-low.
- `level`  in  LW  raw switch selection.
- `ready`  in  1  user ready switch.
- `gameSpeed`  out  LW  current speed code (0 = slowest).
- `control`  out  1  high once the selection is locked.
- `tick`  out  1  one-cycle game-step strobe; only while locked.
- `at_max`  out  1  high when `gameSpeed == LEVELS-1`.

## Operation
- States, encoded in the package:
  - S_WAIT: waiting for `ready`.
  - S_ARM: selection in progress.
  - S_LOCK: selection locked.
- S_WAIT: `control`=0. `ready`=1 → S_ARM; otherwise stay.
- S_ARM: `control`=0.
  - Each cycle, `gameSpeed` ← clamp(`level`); values ≥ LEVELS clamp to LEVELS-1.
  - `ready`=0 → S_LOCK; otherwise stay.
- S_LOCK: `control`=1; `level` and `ready` are ignored. The block leaves S_LOCK only on reset.
- Prescaler:
  - Active only in S_LOCK; held at 0 in all other states.
  - period(s) = max(1, BASE_PERIOD >> s).
  - The counter counts 0..period-1; `tick`=1 on the cycle the count equals period-1, then the counter wraps to 0.
- Auto-advance, only when `AUTO_ADV`=1:
  - A tick counter counts the ticks taken at the current level.
  - On the ADV_TICKS-th tick, if `gameSpeed` < LEVELS-1: `gameSpeed` increments by 1, and the tick counter and prescaler both clear.
  - At LEVELS-1 there is no further change, and the counters keep running without effect.
- `at_max` is combinational from `gameSpeed`.
- Default/illegal state → S_WAIT with `gameSpeed`=0.

## Timing
- Reset (async assert, sync release): state=S_WAIT, `gameSpeed`=0, `control`=0, `tick`=0, counters=0. `at_max`=0 unless LEVELS=1 (disallowed).
- Reset asserted mid-operation (any state, including mid-period) clears everything immediately; no tick is emitted.
- `gameSpeed` follows `level` with one-cycle register latency while in S_ARM.
- The edge that samples `ready`=0 in S_ARM sets state=S_LOCK and `control`=1 together. The `gameSpeed` value latched on that same edge (from the final `level` sample) is final.
- First `tick` comes period(gameSpeed) cycles after `control` rises.
- Successive ticks are exactly period cycles apart.
- On an auto-advance edge, the new period takes effect from count 0, so the next tick is period(new) cycles later.
- Period 1: `tick` is high every locked cycle.
- `ready` toggling in S_LOCK has no effect.

## Structure
- Package `game_pkg`: state enum; the `clamp_level` and `period_of` functions.
- Sub-module `tick_prescaler` (inputs: `clk`, `rst`, `en`, `clr`, `period[CNT_W]`; output: `tick`).
- The FSM, auto-advance counter and clamp logic live in the top module.

## Test plan
All scenarios use LEVELS=4, BASE_PERIOD=16 (periods 16/8/4/2), unless stated.
- Reset, then `ready`=1 with `level`=2, then `ready`=0 → `gameSpeed`=2 and `control`=1 on the same edge; first `tick` 4 cycles later, then every 4 cycles.
- `level` changed 1→3→0 while in S_ARM → `gameSpeed` tracks it with 1-cycle lag; final lock value is 0 and the tick period is 16.
- LEVELS=3, `level`=3 → clamped to 2; `at_max`=1; the tick period is 4.
- `AUTO_ADV`=1, ADV_TICKS=2, lock at 0 → speed 0→1 after 32 cycles, 1→2 after 16 more, 2→3 after 8 more. `at_max`=1 afterward, and ticks continue every 2 cycles.
- After lock, toggle `ready` and `level` → no change to `gameSpeed`, `control` or the tick cadence.
- Assert `rst` asynchronously mid-period in S_LOCK → all outputs are 0 immediately, with no clock edge needed; after release the block is in S_WAIT.
